spi_slave_port: RTL and testbench
=================================

Name: spi_slave_port

Overview:
- SPI slave (responder) companion to the system's SPI master core, fixed at mode 0 (CPOL=0, CPHA=0), 8 data bits, MSB first.
- Lets the Nios system act as a peripheral on an external SPI bus.
- Exposes the same CPU-side register interface style as the master: rx data, tx data, status and control registers, with two-cycle read/write access and a level irq.
- All SPI pins are oversampled in the system clock domain; there is no SCLK-clocked logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages on SCLK/SS_n/MOSI input synchronizers (min 2)
TX_IDLE, 8'h00, byte shifted out when a byte slot starts with no tx data loaded

Ports:
clk  in  1  system clock; SCLK half-period must be >= SYNC_STAGES+2 clk cycles
reset_n  in  1  asynchronous active-low reset
SCLK  in  1  SPI clock from external master
SS_n  in  1  slave select, active low
MOSI  in  1  serial data from master
MISO  out  1  serial data to master
MISO_oe  out  1  MISO output enable (1 while selected)
data_from_cpu  in  16  CPU write data
mem_addr  in  3  register address
read_n  in  1  read request, active low
write_n  in  1  write request, active low
spi_select  in  1  chip select from the bus fabric
data_to_cpu  out  16  registered read data
dataavailable  out  1  equals RRDY
readyfordata  out  1  equals TRDY
irq  out  1  registered interrupt

Behaviour:
- Reset values: all registers 0, except tx shift = TX_IDLE. Outputs: MISO=TX_IDLE[7], MISO_oe=0, data_to_cpu=0, irq=0, RRDY=0, TRDY=1.
- Register map:
  - 0 rx data (r)
  - 1 tx data (w)
  - 2 status (r; any write clears ROE/TOE/TUR/RRDY)
  - 3 control (r/w)
  - 4-7: read 0, writes ignored
- Status bits: [3] ROE, [4] TOE, [5] TMT, [6] TRDY, [7] RRDY, [8] E = ROE|TOE|TUR, [9] TUR (tx underrun).
- Control bits (interrupt enables): [3] iROE, [4] iTOE, [6] iTRDY, [7] iRRDY, [8] iE.
- Bus access:
  - Read and write are two-cycle. First-cycle strobe = spi_select & ~rd/wr_n & ~strobe_reg; the action occurs on the registered strobe.
  - data_to_cpu is registered from the mem_addr mux every cycle.
  - An rx data read clears RRDY on the registered strobe.
- irq = registered OR of each flag with its enable: ROE&iROE, TOE&iTOE, TRDY&iTRDY, RRDY&iRRDY, E&iE.
- Input conditioning: SCLK, SS_n and MOSI pass through SYNC_STAGES flops. Rise/fall pulses are derived from the synchronized SCLK delayed by one flop. Edges are ignored while synchronized SS_n=1.
- Frame states: IDLE -> SELECTED (synced SS_n falling) -> IDLE (synced SS_n rising).
- On entering SELECTED, at the same clk:
  - tx shift <= tx_holding if primed, else TX_IDLE with TUR set.
  - primed clears; bit count = 0.
  - MISO_oe=1; MISO = tx shift[7] continuously.
- SCLK rise while selected: rx shift <= {rx shift[6:0], MOSI_sync}; count+1.
- SCLK fall while selected:
  - count != 8: tx shift <= {tx shift[6:0], 0}.
  - count == 8: byte complete. tx shift reloads from holding (or TX_IDLE with TUR set); count=0. This gives back-to-back bytes with SS_n held low.
- Byte complete (8th rise): rx_holding <= assembled byte. If RRDY is already 1, set ROE and overwrite. RRDY=1.
- TRDY = ~primed. A tx write while primed sets TOE, and holding is unchanged.
- A tx write coincident with a load into the shift register: the load takes the old holding value, and the new write primes holding (primed stays 1).
- TMT = ~primed & ~selected.
- SS_n rising mid-byte (count 1-7): partial rx byte discarded, no RRDY, count=0. MISO_oe=0 on the same clk as synced SS_n rising.
- Status write coincident with a flag-setting event: the set wins.
- Reset asserted mid-frame: immediate return to reset values. The frame is ignored until the next SS_n falling edge.

Test Plan:
- Write 0xA5 to addr 1, master clocks one mode-0 byte with MOSI=0x3C -> MISO bits 1,0,1,0,0,1,0,1. Addr 0 reads 0x003C; RRDY=1 then 0 after the read; TRDY back to 1 at SS_n fall.
- Two bytes with SS_n held low, holding reloaded with 0x81 after the first load -> second MISO byte 0x81. With no reload, second byte = TX_IDLE and status[9] TUR=1.
- Two rx bytes without a CPU read -> ROE=1, rx data = second byte. Status write clears ROE/TUR/RRDY to 0.
- Two tx writes before SS_n falls -> TOE=1, first value retained and shifted out; with iTOE=1, irq=1 within 2 clk.
- SS_n deasserted after 4 SCLK rises -> RRDY stays 0, MISO_oe=0; next full byte is received correctly.
- reset_n pulsed low mid-byte -> all outputs at reset values asynchronously; subsequent frame correct.

Source files
------------

// File: rtl/spi_slave_port.sv
// Mode-0 SPI responder (8-bit, MSB first) with a CPU register window.
// All SPI pins are oversampled in the clk domain; nothing is clocked by SCLK.
module spi_slave_port #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  TX_IDLE     = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic [15:0] data_from_cpu,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic [15:0] data_to_cpu,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        irq
);

    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BUS_W  = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEL  = 1'b1;

    localparam logic [2:0] A_RXDATA = 3'd0;
    localparam logic [2:0] A_TXDATA = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;

    // Input synchronizers plus one delay flop each for edge detection
    logic [SYNC_N-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
    logic              sclk_dly_q, ss_dly_q;

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_hold_q, rx_hold_d;
    logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              primed_q, primed_d;
    logic              roe_q, roe_d;
    logic              toe_q, toe_d;
    logic              tur_q, tur_d;
    logic              rrdy_q, rrdy_d;
    logic              iroe_q, iroe_d;
    logic              itoe_q, itoe_d;
    logic              itrdy_q, itrdy_d;
    logic              irrdy_q, irrdy_d;
    logic              ie_q, ie_d;
    logic              rd_stb_q, rd_stb_d;
    logic              wr_stb_q, wr_stb_d;
    logic [BUS_W-1:0]  rdata_q, rdata_d;
    logic              irq_q, irq_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise_c, sclk_fall_c, ss_fall_c, ss_rise_c;
    logic load_c, byte_done_c;
    logic trdy_c, tmt_c, err_c;
    logic wr_act_c, rd_act_c;
    logic unused_c;

    assign sclk_s = sclk_sync_q[SYNC_N-1];
    assign ss_s   = ss_sync_q[SYNC_N-1];
    assign mosi_s = mosi_sync_q[SYNC_N-1];

    assign sclk_rise_c = sclk_s & ~sclk_dly_q & ~ss_s;
    assign sclk_fall_c = ~sclk_s & sclk_dly_q & ~ss_s;
    assign ss_fall_c   = ~ss_s & ss_dly_q;
    assign ss_rise_c   = ss_s & ~ss_dly_q;

    assign trdy_c   = ~primed_q;
    assign tmt_c    = ~primed_q & (state_q == ST_IDLE);
    assign err_c    = roe_q | toe_q | tur_q;
    assign wr_act_c = wr_stb_q;
    assign rd_act_c = rd_stb_q;

    assign unused_c = ^{data_from_cpu[15:9], data_from_cpu[5], data_from_cpu[2:0]};

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_hold_d   = rx_hold_q;
        tx_hold_d   = tx_hold_q;
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        roe_d       = roe_q;
        toe_d       = toe_q;
        tur_d       = tur_q;
        rrdy_d      = rrdy_q;
        iroe_d      = iroe_q;
        itoe_d      = itoe_q;
        itrdy_d     = itrdy_q;
        irrdy_d     = irrdy_q;
        ie_d        = ie_q;
        load_c      = 1'b0;
        byte_done_c = 1'b0;

        rd_stb_d = spi_select & ~read_n & ~rd_stb_q;
        wr_stb_d = spi_select & ~write_n & ~wr_stb_q;

        case (state_q)
            ST_IDLE: begin
                if (ss_fall_c) begin
                    state_d = ST_SEL;
                    load_c  = 1'b1;
                end
            end
            ST_SEL: begin
                if (ss_rise_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (sclk_rise_c) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(7)) begin
                        byte_done_c = 1'b1;
                    end
                end else if (sclk_fall_c) begin
                    if (cnt_q == CNT_W'(8)) begin
                        load_c = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shift register load at frame start and at each byte boundary
        if (load_c) begin
            cnt_d    = '0;
            primed_d = 1'b0;
            if (primed_q) begin
                tx_shift_d = tx_hold_q;
            end else begin
                tx_shift_d = TX_IDLE;
            end
        end

        // CPU clears come first so that same-cycle hardware sets win
        if (wr_act_c && (mem_addr == A_STATUS)) begin
            roe_d  = 1'b0;
            toe_d  = 1'b0;
            tur_d  = 1'b0;
            rrdy_d = 1'b0;
        end
        if (rd_act_c && (mem_addr == A_RXDATA)) begin
            rrdy_d = 1'b0;
        end
        if (wr_act_c && (mem_addr == A_CTRL)) begin
            iroe_d  = data_from_cpu[3];
            itoe_d  = data_from_cpu[4];
            itrdy_d = data_from_cpu[6];
            irrdy_d = data_from_cpu[7];
            ie_d    = data_from_cpu[8];
        end

        if (load_c && !primed_q) begin
            tur_d = 1'b1;
        end
        if (byte_done_c) begin
            rx_hold_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            rrdy_d    = 1'b1;
            if (rrdy_q) begin
                roe_d = 1'b1;
            end
        end
        // A load in the same cycle frees the holding register for this write
        if (wr_act_c && (mem_addr == A_TXDATA)) begin
            if (primed_q && !load_c) begin
                toe_d = 1'b1;
            end else begin
                tx_hold_d = data_from_cpu[DATA_W-1:0];
                primed_d  = 1'b1;
            end
        end

        case (mem_addr)
            A_RXDATA: rdata_d = {BUS_W'(0)} | BUS_W'(rx_hold_q);
            A_STATUS: rdata_d = {6'd0, tur_q, err_c, rrdy_q, trdy_c, tmt_c,
                                 toe_q, roe_q, 3'd0};
            A_CTRL:   rdata_d = {7'd0, ie_q, irrdy_q, itrdy_q, 1'b0, itoe_q,
                                 iroe_q, 3'd0};
            default:  rdata_d = '0;
        endcase

        irq_d = (roe_q & iroe_q) | (toe_q & itoe_q) | (trdy_c & itrdy_q) |
                (rrdy_q & irrdy_q) | (err_c & ie_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b0;
            state_q     <= ST_IDLE;
            rx_shift_q  <= '0;
            tx_shift_q  <= TX_IDLE;
            rx_hold_q   <= '0;
            tx_hold_q   <= '0;
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            roe_q       <= 1'b0;
            toe_q       <= 1'b0;
            tur_q       <= 1'b0;
            rrdy_q      <= 1'b0;
            iroe_q      <= 1'b0;
            itoe_q      <= 1'b0;
            itrdy_q     <= 1'b0;
            irrdy_q     <= 1'b0;
            ie_q        <= 1'b0;
            rd_stb_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_N-2:0], SCLK};
            ss_sync_q   <= {ss_sync_q[SYNC_N-2:0], SS_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_N-2:0], MOSI};
            sclk_dly_q  <= sclk_s;
            ss_dly_q    <= ss_s;
            state_q     <= state_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_hold_q   <= rx_hold_d;
            tx_hold_q   <= tx_hold_d;
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            roe_q       <= roe_d;
            toe_q       <= toe_d;
            tur_q       <= tur_d;
            rrdy_q      <= rrdy_d;
            iroe_q      <= iroe_d;
            itoe_q      <= itoe_d;
            itrdy_q     <= itrdy_d;
            irrdy_q     <= irrdy_d;
            ie_q        <= ie_d;
            rd_stb_q    <= rd_stb_d;
            wr_stb_q    <= wr_stb_d;
            rdata_q     <= rdata_d;
            irq_q       <= irq_d;
        end
    end

    assign MISO          = tx_shift_q[DATA_W-1];
    assign MISO_oe       = (state_q == ST_SEL);
    assign data_to_cpu   = rdata_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = ~primed_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a mode-0 SPI master model plus a CPU bus model,
// with expected MISO/rx bytes queued at stimulus time and checked on completion.
module tb_spi_slave_port;

    localparam int HALF = 8;

    logic        clk;
    logic        reset_n;
    logic        SCLK, SS_n, MOSI;
    logic        MISO, MISO_oe;
    logic [15:0] data_from_cpu;
    logic [2:0]  mem_addr;
    logic        read_n, write_n, spi_select;
    logic [15:0] data_to_cpu;
    logic        dataavailable, readyfordata, irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] miso_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] m;
    logic [15:0] rd;

    spi_slave_port #(.SYNC_STAGES(2), .TX_IDLE(8'h00)) dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .data_from_cpu(data_from_cpu),
        .mem_addr(mem_addr), .read_n(read_n), .write_n(write_n),
        .spi_select(spi_select), .data_to_cpu(data_to_cpu),
        .dataavailable(dataavailable), .readyfordata(readyfordata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
        clks(2);
        spi_select = 1'b0; write_n = 1'b1; mem_addr = 3'd2;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
        clks(2);
        d = data_to_cpu;
        spi_select = 1'b0; read_n = 1'b1; mem_addr = 3'd2;
    endtask

    task automatic ss_low();
        @(negedge clk);
        SS_n = 1'b0;
        clks(HALF);
    endtask

    task automatic ss_high();
        clks(HALF);
        SS_n = 1'b1;
        clks(HALF);
    endtask

    // Mode 0: MOSI set while SCLK low, MISO sampled on the rising edge
    task automatic spi_bits(input int n, input logic [7:0] mo, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            MOSI = mo[7-i];
            clks(HALF);
            SCLK = 1'b1;
            mi[7-i] = MISO;
            clks(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
        spi_bits(8, mo, mi);
        rx_q.push_back(mo);
    endtask

    task automatic check_miso(input string tag, input logic [7:0] got);
        logic [7:0] exp;
        if (miso_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(miso_q.size()), 32'd1);
        end else begin
            exp = miso_q.pop_front();
            check(tag, 32'(got), 32'(exp));
        end
    endtask

    // Overwritten bytes are dropped: the newest completed byte is what rx data holds
    task automatic check_rx(input string tag, input logic [15:0] got);
        logic [7:0] exp;
        if (rx_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(rx_q.size()), 32'd1);
        end else begin
            exp = rx_q[rx_q.size()-1];
            rx_q.delete();
            check(tag, 32'(got), {24'd0, exp});
        end
    endtask

    initial begin
        reset_n = 1'b0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        data_from_cpu = 16'h0; mem_addr = 3'd2;
        read_n = 1'b1; write_n = 1'b1; spi_select = 1'b0;
        clks(3);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_miso_oe", 32'(MISO_oe), 32'd0);
        check("rst_data_to_cpu", 32'(data_to_cpu), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rrdy", 32'(dataavailable), 32'd0);
        check("rst_trdy", 32'(readyfordata), 32'd1);
        reset_n = 1'b1;
        clks(4);
        check("idle_status", 32'(data_to_cpu), 32'h60);

        // Single byte transfer
        cpu_write(3'd1, 16'h00A5);
        miso_q.push_back(8'hA5);
        check("t1_trdy_primed", 32'(readyfordata), 32'd0);
        ss_low();
        check("t1_trdy_after_load", 32'(readyfordata), 32'd1);
        check("t1_miso_oe", 32'(MISO_oe), 32'd1);
        spi_byte(8'h3C, m);
        check_miso("t1_miso_byte", m);
        clks(4);
        check("t1_rrdy_set", 32'(dataavailable), 32'd1);
        ss_high();
        check("t1_miso_oe_off", 32'(MISO_oe), 32'd0);
        cpu_read(3'd0, rd);
        check_rx("t1_rx_data", rd);
        clks(1);
        check("t1_rrdy_cleared", 32'(dataavailable), 32'd0);

        // Back-to-back bytes, reload then underrun, and rx overrun
        cpu_write(3'd1, 16'h005A);
        miso_q.push_back(8'h5A);
        ss_low();
        cpu_write(3'd1, 16'h0081);
        miso_q.push_back(8'h81);
        miso_q.push_back(8'h00);
        spi_byte(8'h11, m);
        check_miso("t2_byte0", m);
        spi_byte(8'h22, m);
        check_miso("t2_byte1_reload", m);
        spi_byte(8'h33, m);
        check_miso("t2_byte2_idle", m);
        ss_high();
        cpu_read(3'd2, rd);
        check("t2_tur", 32'(rd[9]), 32'd1);
        check("t2_roe", 32'(rd[3]), 32'd1);
        check("t2_err", 32'(rd[8]), 32'd1);
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd2, rd);
        check("t2_status_cleared", 32'(rd & 16'h0398), 32'd0);
        cpu_read(3'd0, rd);
        check_rx("t2_rx_last", rd);

        // TX overrun with interrupt
        cpu_write(3'd3, 16'h0010);
        clks(2);
        check("t3_irq_quiet", 32'(irq), 32'd0);
        cpu_write(3'd1, 16'h00C3);
        miso_q.push_back(8'hC3);
        cpu_write(3'd1, 16'h0077);
        clks(1);
        check("t3_irq_toe", 32'(irq), 32'd1);
        cpu_read(3'd2, rd);
        check("t3_toe", 32'(rd[4]), 32'd1);
        ss_low();
        spi_byte(8'h00, m);
        check_miso("t3_first_kept", m);
        ss_high();
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd3, 16'h0000);
        clks(2);
        check("t3_irq_cleared", 32'(irq), 32'd0);
        rx_q.delete();

        // Frame abort after four bits, then a full byte
        ss_low();
        spi_bits(4, 8'hF0, m);
        ss_high();
        check("t4_abort_oe", 32'(MISO_oe), 32'd0);
        check("t4_abort_rrdy", 32'(dataavailable), 32'd0);
        miso_q.push_back(8'h00);
        ss_low();
        spi_byte(8'h96, m);
        check_miso("t4_idle_byte", m);
        ss_high();
        cpu_read(3'd0, rd);
        check_rx("t4_rx_after_abort", rd);

        // Reset asserted mid-byte
        cpu_write(3'd3, 16'h0100);
        clks(2);
        check("t5_irq_err", 32'(irq), 32'd1);
        cpu_write(3'd1, 16'h00E7);
        ss_low();
        cpu_write(3'd1, 16'h0012);
        spi_bits(1, 8'hFF, m);
        clks(4);
        check("t5_pre_miso", 32'(MISO), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5_rst_miso", 32'(MISO), 32'd0);
        check("t5_rst_oe", 32'(MISO_oe), 32'd0);
        check("t5_rst_data", 32'(data_to_cpu), 32'd0);
        check("t5_rst_irq", 32'(irq), 32'd0);
        check("t5_rst_rrdy", 32'(dataavailable), 32'd0);
        check("t5_rst_trdy", 32'(readyfordata), 32'd1);
        clks(2);
        reset_n = 1'b1;
        rx_q.delete();
        spi_bits(7, 8'hAA, m);
        clks(4);
        check("t5_ignored_oe", 32'(MISO_oe), 32'd0);
        check("t5_ignored_rrdy", 32'(dataavailable), 32'd0);
        ss_high();
        cpu_write(3'd1, 16'h003E);
        miso_q.push_back(8'h3E);
        ss_low();
        spi_byte(8'h5B, m);
        check_miso("t5_post_reset_miso", m);
        ss_high();
        cpu_read(3'd0, rd);
        check_rx("t5_post_reset_rx", rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
